// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned ADDR_W        = 16;
   localparam int unsigned FETCH_INSTR_W = 16;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]        addr;
      logic [FETCH_INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {addr, instr} entries for decode.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = fetch_entry_t
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  entry_t                 push_data,
   input  logic                   pop,
   input  logic                   clear,
   output logic [$clog2(DEPTH):0] count,
   output logic                   valid,
   output entry_t                 head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   entry_t             mem_q [DEPTH];
   entry_t             mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               do_pop;

   // Clear wins over push/pop; a pop on empty is dropped.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && (count_q != '0);
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;
   assign valid = (count_q != '0);
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues PC-driven reads, buffers responses, freezes or redirects the PC.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned INSTR_W = 16
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic signed [ADDR_W-1:0] CounterValue,
   output logic signed [ADDR_W-1:0] LoadValue,
   output logic                     LoadEnable,
   output logic [ADDR_W-1:0]        MemAddress,
   output logic                     MemReadEnable,
   input  logic [INSTR_W-1:0]       MemData,
   output logic                     InstrValid,
   output logic [INSTR_W-1:0]       InstrData,
   output logic [ADDR_W-1:0]        InstrAddress,
   input  logic                     InstrReady,
   input  logic                     RedirectValid,
   input  logic signed [8:0]        RedirectOffset
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned SUM_W = CNT_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   fetch_state_t        state_q, state_d;
   logic                inflight_q, inflight_d;
   logic [ADDR_W-1:0]   issued_addr_q, issued_addr_d;

   logic [CNT_W-1:0]    fifo_count;
   logic                fifo_valid;
   entry_t              fifo_head;
   entry_t              push_data;
   logic                fifo_push, fifo_pop, fifo_clear;
   logic                redirect, can_issue;
   logic [ADDR_W-1:0]   target;

   // Space check counts the outstanding read; a same-cycle pop never frees room.
   assign can_issue = (SUM_W'(fifo_count) + SUM_W'(inflight_q)) < SUM_W'(DEPTH);
   assign redirect  = (state_q == RUN) && RedirectValid && fifo_valid;
   assign target    = fifo_head.addr + ADDR_W'(RedirectOffset);
   assign push_data = '{addr: issued_addr_q, instr: MemData};

   always_comb begin
      state_d       = state_q;
      inflight_d    = 1'b0;
      issued_addr_d = issued_addr_q;
      LoadEnable    = 1'b0;
      LoadValue     = '0;
      MemReadEnable = 1'b0;
      MemAddress    = '0;
      fifo_push     = 1'b0;
      fifo_pop      = 1'b0;
      fifo_clear    = 1'b0;
      if (Reset) begin
         case (state_q)
            FLUSH: begin
               LoadEnable = 1'b1;
               LoadValue  = CounterValue;
               state_d    = RUN;
            end
            RUN: begin
               if (redirect) begin
                  LoadEnable = 1'b1;
                  LoadValue  = $signed(target);
                  fifo_clear = 1'b1;
                  state_d    = FLUSH;
               end else begin
                  fifo_push = inflight_q;
                  fifo_pop  = fifo_valid && InstrReady;
                  if (can_issue) begin
                     MemReadEnable = 1'b1;
                     MemAddress    = $unsigned(CounterValue);
                     inflight_d    = 1'b1;
                     issued_addr_d = $unsigned(CounterValue);
                  end else begin
                     // Freeze the PC so no address is skipped while the buffer is full.
                     LoadEnable = 1'b1;
                     LoadValue  = CounterValue;
                  end
               end
            end
            default: state_d = FLUSH;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q       <= FLUSH;
         inflight_q    <= 1'b0;
         issued_addr_q <= '0;
      end else begin
         state_q       <= state_d;
         inflight_q    <= inflight_d;
         issued_addr_q <= issued_addr_d;
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk       (Clock),
      .rst_n     (Reset),
      .push      (fifo_push),
      .push_data (push_data),
      .pop       (fifo_pop),
      .clear     (fifo_clear),
      .count     (fifo_count),
      .valid     (fifo_valid),
      .head      (fifo_head)
   );

   assign InstrValid   = fifo_valid;
   assign InstrData    = fifo_head.instr;
   assign InstrAddress = fifo_head.addr;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: PC and memory models plus a transaction-level fetch model.
module tb_instruction_fetch;

   localparam int DEPTH = 4;

   logic               Clock;
   logic               Reset;
   logic [15:0]        pc;
   logic [15:0]        LoadValue;
   logic               LoadEnable;
   logic [15:0]        MemAddress;
   logic               MemReadEnable;
   logic [15:0]        MemData;
   logic               InstrValid;
   logic [15:0]        InstrData;
   logic [15:0]        InstrAddress;
   logic               InstrReady;
   logic               RedirectValid;
   logic signed [8:0]  RedirectOffset;

   instruction_fetch #(.DEPTH(DEPTH), .INSTR_W(16)) dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .CounterValue   (pc),
      .LoadValue      (LoadValue),
      .LoadEnable     (LoadEnable),
      .MemAddress     (MemAddress),
      .MemReadEnable  (MemReadEnable),
      .MemData        (MemData),
      .InstrValid     (InstrValid),
      .InstrData      (InstrData),
      .InstrAddress   (InstrAddress),
      .InstrReady     (InstrReady),
      .RedirectValid  (RedirectValid),
      .RedirectOffset (RedirectOffset)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Program counter: +1 per cycle unless loaded.
   always @(posedge Clock) begin
      if (!Reset)          pc <= 16'h0000;
      else if (LoadEnable) pc <= LoadValue;
      else                 pc <= pc + 16'd1;
   end

   // Synchronous memory; unrequested cycles return junk.
   always @(posedge Clock) begin
      if (MemReadEnable) MemData <= MemAddress ^ 16'hA5A5;
      else               MemData <= 16'($urandom);
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Model: every fetched address, in order, with the first cycle it may be seen.
   typedef struct {
      logic [15:0] addr;
      int          avail;
   } fetch_t;

   fetch_t      mq[$];
   int          cyc     = 0;
   bit          m_flush = 1'b1;
   logic [15:0] last_lv;

   function automatic bit m_head_ok(input logic [15:0] a);
      return (mq.size() > 0) && (mq[0].avail <= cyc) && (mq[0].addr == a);
   endfunction

   task automatic tick(input bit rst_n, input bit rdy, input bit rv, input logic signed [8:0] off);
      bit          e_valid, e_issue, take_redir;
      logic [15:0] tgt;
      Reset          = rst_n;
      InstrReady     = rdy;
      RedirectValid  = rv;
      RedirectOffset = off;
      @(negedge Clock);
      last_lv    = LoadValue;
      e_valid    = (mq.size() > 0) && (mq[0].avail <= cyc);
      take_redir = 1'b0;
      e_issue    = 1'b0;
      tgt        = 16'h0000;
      check_eq("instr_valid", InstrValid, e_valid);
      if (e_valid) begin
         check_eq("instr_addr", InstrAddress, mq[0].addr);
         check_eq("instr_data", InstrData, mq[0].addr ^ 16'hA5A5);
      end
      if (!rst_n) begin
         check_eq("rst_load_en", LoadEnable, 1'b0);
         check_eq("rst_load_val", LoadValue, 16'h0000);
         check_eq("rst_mem_re", MemReadEnable, 1'b0);
         check_eq("rst_mem_addr", MemAddress, 16'h0000);
         mq.delete();
         m_flush = 1'b1;
      end else begin
         take_redir = !m_flush && e_valid && rv;
         e_issue    = !m_flush && !take_redir && (mq.size() < DEPTH);
         if (take_redir) tgt = mq[0].addr + 16'(off);
         check_eq("mem_re", MemReadEnable, e_issue);
         check_eq("load_en", LoadEnable, !e_issue);
         if (e_issue)         check_eq("mem_addr", MemAddress, pc);
         else if (take_redir) check_eq("redir_target", LoadValue, tgt);
         else                 check_eq("hold_value", LoadValue, pc);
         if (take_redir) begin
            mq.delete();
            m_flush = 1'b1;
         end else begin
            m_flush = 1'b0;
            if (e_valid && rdy) void'(mq.pop_front());
            if (e_issue) mq.push_back('{addr: pc, avail: cyc + 2});
         end
      end
      cyc++;
      @(posedge Clock);
      #1;
   endtask

   // Counts cycles until the DUT presents a valid head, bounded.
   task automatic wait_valid(input int start, output int n);
      n = start;
      while (!InstrValid && n < 12) begin
         tick(1'b1, 1'b1, 1'b0, 9'sd0);
         n++;
      end
   endtask

   int               n;
   int               nv;
   bit               r_rst, r_rdy, r_rv;
   logic signed [8:0] r_off;

   initial begin
      Reset          = 1'b0;
      InstrReady     = 1'b0;
      RedirectValid  = 1'b0;
      RedirectOffset = 9'sd0;
      repeat (2) @(posedge Clock);
      #1;

      // Reset values, fill latency, redirect targets including wrap.
      tick(1'b0, 1'b1, 1'b0, 9'sd0);
      tick(1'b0, 1'b1, 1'b0, 9'sd0);
      check_eq("rst_instr_data", InstrData, 16'h0000);
      check_eq("rst_instr_addr", InstrAddress, 16'h0000);
      wait_valid(0, n);
      check_eq("first_valid_lat", n, 3);
      check_eq("first_addr", InstrAddress, 16'h0000);

      tick(1'b1, 1'b1, 1'b1, -9'sd16);
      check_eq("redir_neg16_lv", last_lv, 16'hFFF0);
      wait_valid(1, n);
      check_eq("redir_lat_a", n, 4);
      check_eq("redir_addr_a", InstrAddress, 16'hFFF0);

      n = 0;
      while (!m_head_ok(16'h0010) && n < 60) begin
         tick(1'b1, 1'b1, 1'b0, 9'sd0);
         n++;
      end
      check_eq("wrap_stream_len", n, 32);

      tick(1'b1, 1'b1, 1'b1, -9'sd3);
      check_eq("redir_m3_lv", last_lv, 16'h000D);
      wait_valid(1, n);
      check_eq("redir_lat_b", n, 4);
      check_eq("redir_addr_b", InstrAddress, 16'h000D);

      tick(1'b1, 1'b1, 1'b1, -9'sd29);
      wait_valid(1, n);
      check_eq("redir_addr_c", InstrAddress, 16'hFFF0);
      tick(1'b1, 1'b1, 1'b1, 9'sd255);
      check_eq("redir_p255_lv", last_lv, 16'h00EF);
      wait_valid(1, n);
      check_eq("redir_lat_d", n, 4);
      check_eq("redir_addr_d", InstrAddress, 16'h00EF);

      // Backpressure fill with redirect requested while nothing is valid.
      tick(1'b0, 1'b0, 1'b0, 9'sd0);
      for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, (i < 3), 9'sd100);
      check_eq("hold_pc", pc, 16'h0004);
      check_eq("hold_load_en", LoadEnable, 1'b1);
      check_eq("hold_load_val", LoadValue, 16'h0004);
      check_eq("hold_mem_re", MemReadEnable, 1'b0);
      nv = 0;
      for (int i = 0; i < 12; i++) begin
         if (InstrValid) nv++;
         tick(1'b1, 1'b1, 1'b0, 9'sd0);
      end
      check_eq("release_no_gap", nv, 12);

      // Reset with three buffered entries and a read in flight.
      tick(1'b0, 1'b0, 1'b0, 9'sd0);
      n = 0;
      while (!(mq.size() == DEPTH && mq[DEPTH-1].avail > cyc) && n < 20) begin
         tick(1'b1, 1'b0, 1'b0, 9'sd0);
         n++;
      end
      check_eq("midflight_reach", n, 5);
      tick(1'b0, 1'b0, 1'b0, 9'sd0);
      check_eq("midflight_rst_valid", InstrValid, 1'b0);
      wait_valid(0, n);
      check_eq("midflight_lat", n, 3);
      check_eq("midflight_addr", InstrAddress, 16'h0000);
      check_eq("midflight_data", InstrData, 16'hA5A5);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         r_rst = ($urandom_range(0, 99) != 0);
         r_rdy = ($urandom_range(0, 3) != 0);
         r_rv  = ($urandom_range(0, 15) == 0);
         r_off = 9'($urandom);
         tick(r_rst, r_rdy, r_rv, r_off);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1);
   end

endmodule
